// File: rtl/digit_counter_chain.sv
`timescale 1ns/1ps
// Purpose: registered multi-digit modulo-L counter built from a ripple chain of
//          lim_inc stages, with run/stop/done FSM, tick prescaler and wrap/saturate policy.
// Latency: one clk from count event (inc or tick) to updated digits; no backpressure (pulse inputs).

// Single combinational limited-increment stage: sum = (a + ci) mod L, co when it rolls over.
// Any input >= L-1 with ci set produces carry-out and zero, so digits can never exceed L-1.
module lim_inc #(
  parameter int L = 10,
  parameter int W = $clog2(L)
) (
  input  logic [W-1:0] a_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);

  localparam logic [W-1:0] DMAX = W'(L - 1);

  // Roll over at (or above) the top digit value, otherwise plain add of the carry-in.
  always_comb begin
    co_o  = ci_i && (a_i >= DMAX);
    sum_o = co_o ? '0 : (a_i + W'(ci_i));
  end

endmodule

module digit_counter_chain #(
  parameter int DIGITS   = 4,
  parameter int L        = 10,
  parameter int W        = $clog2(L),
  parameter int PRESCALE = 0,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clr,
  input  logic                 inc,
  output logic [DIGITS*W-1:0]  digits,
  output logic                 at_max,
  output logic                 wrap,
  output logic                 running
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Prescaler needs at least one bit even when auto ticking is disabled.
  localparam int           PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'((PRESCALE > 0) ? (PRESCALE - 1) : 0);
  localparam logic [W-1:0]  DMAX = W'(L - 1);

  state_e               state_q, state_d;
  logic [DIGITS*W-1:0]  digits_q, digits_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 at_max_q, at_max_d;
  logic                 wrap_q, wrap_d;
  logic                 running_q, running_d;

  logic [DIGITS:0]      carry;
  logic [DIGITS*W-1:0]  sum_all;
  logic                 tick;
  logic                 ev;
  logic                 full;

  // Ripple chain: digit 0 always gets carry-in 1, each later digit takes the previous carry-out.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    lim_inc #(
      .L (L),
      .W (W)
    ) u_lim_inc (
      .a_i   (digits_q[g*W +: W]),
      .ci_i  (carry[g]),
      .sum_o (sum_all[g*W +: W]),
      .co_o  (carry[g+1])
    );
  end

  // With ci0 tied high, the final carry-out is set exactly when every digit sits at L-1.
  assign full = carry[DIGITS];

  // Auto tick fires on the last prescaler count while running; inc and tick merge into one event.
  always_comb begin
    tick = (PRESCALE > 0) && (state_q == ST_RUNNING) && (presc_q == PMAX);
    ev   = (state_q == ST_RUNNING) && (inc || tick);
  end

  // Next-state for FSM, digits, prescaler and wrap pulse; clr overrides everything else.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    wrap_d   = 1'b0;

    if (clr) begin
      state_d  = ST_STOPPED;
      digits_d = '0;
      presc_d  = '0;
    end else begin
      // Prescaler only advances while running; any other state parks it at zero.
      if ((PRESCALE == 0) || (state_q != ST_RUNNING) || tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end

      // At full count the chain result is already all-zero; saturating mode keeps the old value.
      if (ev && !(SATURATE && full)) begin
        digits_d = sum_all;
      end

      wrap_d = ev && full && !SATURATE;

      case (state_q)
        ST_STOPPED: begin
          if (start) begin
            state_d = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (ev && full && SATURATE) begin
            state_d = ST_DONE;
          end else if (stop) begin
            state_d = ST_STOPPED;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_STOPPED;
        end
      endcase
    end
  end

  // at_max is derived from the next digit value so the flag lines up with the digits register.
  always_comb begin
    at_max_d = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_d[i*W +: W] != DMAX) begin
        at_max_d = 1'b0;
      end
    end
    running_d = (state_d == ST_RUNNING);
  end

  // State, digits, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STOPPED;
      digits_q  <= '0;
      presc_q   <= '0;
      at_max_q  <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      at_max_q  <= at_max_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign digits  = digits_q;
  assign at_max  = at_max_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_digit_counter_chain.sv
`timescale 1ns/1ps
// Purpose: directed check of digit_counter_chain in three configurations
//          (prescaled wrap, inc-only wrap, inc-only saturate), two BCD digits.
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
module tb_digit_counter_chain;

  logic       clk;
  logic       reset_n;
  logic [2:0] start_v, stop_v, clr_v, inc_v;
  logic [7:0] dig_p, dig_i, dig_s;
  logic [2:0] at_max_v, wrap_v, run_v;

  int n_chk  = 0;
  int n_fail = 0;

  // Index 0: PRESCALE=4 wrap, index 1: PRESCALE=0 wrap, index 2: PRESCALE=0 saturate.
  digit_counter_chain #(.DIGITS(2), .L(10), .PRESCALE(4), .SATURATE(1'b0)) dut_p (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .stop(stop_v[0]), .clr(clr_v[0]),
    .inc(inc_v[0]), .digits(dig_p), .at_max(at_max_v[0]), .wrap(wrap_v[0]), .running(run_v[0]));

  digit_counter_chain #(.DIGITS(2), .L(10), .PRESCALE(0), .SATURATE(1'b0)) dut_i (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .stop(stop_v[1]), .clr(clr_v[1]),
    .inc(inc_v[1]), .digits(dig_i), .at_max(at_max_v[1]), .wrap(wrap_v[1]), .running(run_v[1]));

  digit_counter_chain #(.DIGITS(2), .L(10), .PRESCALE(0), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .stop(stop_v[2]), .clr(clr_v[2]),
    .inc(inc_v[2]), .digits(dig_s), .at_max(at_max_v[2]), .wrap(wrap_v[2]), .running(run_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic start_pulse(input int k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic stop_pulse(input int k);
    stop_v[k] = 1'b1;
    @(negedge clk);
    stop_v[k] = 1'b0;
  endtask

  task automatic clr_pulse(input int k);
    clr_v[k] = 1'b1;
    @(negedge clk);
    clr_v[k] = 1'b0;
  endtask

  task automatic inc_hold(input int k, input int n);
    inc_v[k] = 1'b1;
    repeat (n) @(negedge clk);
    inc_v[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_v = '0;
    stop_v  = '0;
    clr_v   = '0;
    inc_v   = '0;

    // Reset state of all three instances.
    #3;
    check_eq("rst_dig_p", {24'd0, dig_p}, 32'h00);
    check_eq("rst_dig_i", {24'd0, dig_i}, 32'h00);
    check_eq("rst_dig_s", {24'd0, dig_s}, 32'h00);
    check_eq("rst_run",   {29'd0, run_v}, 32'h0);
    check_eq("rst_atmax", {29'd0, at_max_v}, 32'h0);
    check_eq("rst_wrap",  {29'd0, wrap_v}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ---- Async reset mid-run at 37 (prescaled instance; inc every cycle = +1 per cycle)
    start_pulse(0);
    inc_hold(0, 37);
    check_eq("p_reach37", {24'd0, dig_p}, 32'h37);
    check_eq("p_run37",   {31'd0, run_v[0]}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("p_async_dig", {24'd0, dig_p}, 32'h00);
    check_eq("p_async_run", {31'd0, run_v[0]}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- Auto tick: first step 4 clk after start, then every 4 clk
    start_pulse(0);
    check_eq("p_tick_wait0", {24'd0, dig_p}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("p_tick_wait", {24'd0, dig_p}, 32'h00);
    end
    @(negedge clk);
    check_eq("p_tick_first", {24'd0, dig_p}, 32'h01);
    repeat (35) @(negedge clk);
    check_eq("p_tick_09", {24'd0, dig_p}, 32'h09);
    @(negedge clk);
    check_eq("p_tick_10", {24'd0, dig_p}, 32'h10);
    repeat (8) @(negedge clk);
    check_eq("p_tick_12", {24'd0, dig_p}, 32'h12);

    // ---- Stop mid-prescale at 12, wait, restart: next step 4 clk after restart
    @(negedge clk);
    stop_pulse(0);
    check_eq("p_stop_run", {31'd0, run_v[0]}, 32'h0);
    repeat (10) @(negedge clk);
    check_eq("p_stop_hold", {24'd0, dig_p}, 32'h12);
    start_pulse(0);
    repeat (3) @(negedge clk);
    check_eq("p_restart_pre", {24'd0, dig_p}, 32'h12);
    @(negedge clk);
    check_eq("p_restart_step", {24'd0, dig_p}, 32'h13);
    check_eq("p_restart_run",  {31'd0, run_v[0]}, 32'h1);

    // ---- inc coincident with tick counts once
    repeat (3) @(negedge clk);
    inc_hold(0, 1);
    check_eq("p_inc_tick", {24'd0, dig_p}, 32'h14);
    repeat (3) @(negedge clk);
    check_eq("p_after_coin", {24'd0, dig_p}, 32'h14);
    @(negedge clk);
    check_eq("p_next_tick", {24'd0, dig_p}, 32'h15);

    // ---- clr with start and inc at 45: clear wins, prescaler restarts from 0
    clr_pulse(0);
    start_pulse(0);
    inc_hold(0, 45);
    check_eq("p_reach45", {24'd0, dig_p}, 32'h45);
    clr_v[0] = 1'b1; start_v[0] = 1'b1; inc_v[0] = 1'b1;
    @(negedge clk);
    clr_v[0] = 1'b0; start_v[0] = 1'b0; inc_v[0] = 1'b0;
    check_eq("p_clr_dig", {24'd0, dig_p}, 32'h00);
    check_eq("p_clr_run", {31'd0, run_v[0]}, 32'h0);
    start_pulse(0);
    repeat (3) @(negedge clk);
    check_eq("p_clr_presc0", {24'd0, dig_p}, 32'h00);
    @(negedge clk);
    check_eq("p_clr_presc1", {24'd0, dig_p}, 32'h01);

    // ---- inc-only instance: carry into digit 1, inc ignored while stopped
    start_pulse(1);
    inc_hold(1, 8);
    check_eq("i_08", {24'd0, dig_i}, 32'h08);
    inc_hold(1, 1);
    check_eq("i_09", {24'd0, dig_i}, 32'h09);
    inc_hold(1, 1);
    check_eq("i_10", {24'd0, dig_i}, 32'h10);
    inc_hold(1, 1);
    check_eq("i_11", {24'd0, dig_i}, 32'h11);
    stop_pulse(1);
    check_eq("i_stop_run", {31'd0, run_v[1]}, 32'h0);
    inc_hold(1, 1);
    check_eq("i_stop_inc", {24'd0, dig_i}, 32'h11);

    // ---- Wrap at full count
    clr_pulse(1);
    start_pulse(1);
    inc_hold(1, 99);
    check_eq("i_99",       {24'd0, dig_i}, 32'h99);
    check_eq("i_99_atmax", {31'd0, at_max_v[1]}, 32'h1);
    check_eq("i_99_wrap",  {31'd0, wrap_v[1]}, 32'h0);
    inc_hold(1, 1);
    check_eq("i_wrap_dig",   {24'd0, dig_i}, 32'h00);
    check_eq("i_wrap_pulse", {31'd0, wrap_v[1]}, 32'h1);
    check_eq("i_wrap_atmax", {31'd0, at_max_v[1]}, 32'h0);
    check_eq("i_wrap_run",   {31'd0, run_v[1]}, 32'h1);
    @(negedge clk);
    check_eq("i_wrap_end", {31'd0, wrap_v[1]}, 32'h0);

    // ---- Saturate at full count: DONE ignores start/inc, clr leaves
    start_pulse(2);
    inc_hold(2, 99);
    check_eq("s_99",       {24'd0, dig_s}, 32'h99);
    check_eq("s_99_atmax", {31'd0, at_max_v[2]}, 32'h1);
    inc_hold(2, 1);
    check_eq("s_sat_dig",  {24'd0, dig_s}, 32'h99);
    check_eq("s_sat_run",  {31'd0, run_v[2]}, 32'h0);
    check_eq("s_sat_wrap", {31'd0, wrap_v[2]}, 32'h0);
    check_eq("s_sat_atmax", {31'd0, at_max_v[2]}, 32'h1);
    start_pulse(2);
    check_eq("s_done_start", {31'd0, run_v[2]}, 32'h0);
    inc_hold(2, 1);
    check_eq("s_done_inc", {24'd0, dig_s}, 32'h99);
    clr_pulse(2);
    check_eq("s_clr_dig",   {24'd0, dig_s}, 32'h00);
    check_eq("s_clr_run",   {31'd0, run_v[2]}, 32'h0);
    check_eq("s_clr_atmax", {31'd0, at_max_v[2]}, 32'h0);
    start_pulse(2);
    check_eq("s_clr_restart", {31'd0, run_v[2]}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
